// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, color type, palette defaults and pixel-flag bundle.
package vga_pkg;
  localparam int H_START = 158;
  localparam int DISPLAY_W = 640;
  localparam int DISPLAY_H = 480;
  typedef logic [23:0] color_t;
  localparam color_t TRANSPARENT = 24'hFF00FF;
  localparam color_t BG_COLOR = 24'h98FB98;
  localparam color_t GRID_COLOR = 24'h228B22;
  localparam color_t TRACK_COLOR = 24'h808069;
  localparam color_t BOUND_COLOR = 24'hFFFFFF;
  typedef struct packed {
    logic bright;
    logic hsync;
    logic vsync;
    logic pix_en;
    logic bound;
    logic grid;
    logic track;
  } flags_t;
  localparam flags_t FLAGS_RST = '{bright: 1'b0, hsync: 1'b1, vsync: 1'b1, default: 1'b0};
endpackage

// File: rtl/pipe_delay.sv
// pipe_delay: W-bit shift register of depth D with a per-instance reset value.
module pipe_delay #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] r [D];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < D; i++) r[i] <= RST;
    end else begin
      r[0] <= d;
      for (int i = 1; i < D; i++) r[i] <= r[i-1];
    end
  end
  assign q = r[D-1];
endmodule

// File: rtl/glyph_pixel_mux.sv
// glyph_pixel_mux: glyph ROM read, transparency and priority color mux, 3-cycle latency.
// Optional grid layer compiled only when GLYPH_GRID_EN is defined.
module glyph_pixel_mux #(
  parameter int H_START = vga_pkg::H_START,
  parameter int DISPLAY_W = vga_pkg::DISPLAY_W,
  parameter int DISPLAY_H = vga_pkg::DISPLAY_H,
  parameter int BORDER = 4,
  parameter int TRACK_Y0 = 400,
  parameter int TRACK_Y1 = 448,
  parameter int GRID_LOG2 = 5,
  parameter logic [23:0] TRANSPARENT = vga_pkg::TRANSPARENT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bright,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [15:0] glyph_addr,
  input  logic        pix_en,
  input  logic [23:0] bg_color,
  input  logic [23:0] grid_color,
  input  logic [23:0] track_color,
  input  logic [23:0] bound_color,
  output logic [15:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic [23:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        bright_out,
  output logic [7:0]  frame_count
);
  import vga_pkg::*;
  logic [9:0] x_pos;
  logic bound, grid, track;
  flags_t s0, s1, s2;
  logic [71:0] pal;
  color_t grid_c, next_rgb;
  logic [1:0] live;
  assign x_pos = hcount - 10'(H_START);
  assign bound = x_pos < 10'(BORDER) || x_pos >= 10'(DISPLAY_W - BORDER) ||
                 vcount < 10'(BORDER) || vcount >= 10'(DISPLAY_H - BORDER);
  assign track = vcount >= 10'(TRACK_Y0) && vcount < 10'(TRACK_Y1);
`ifdef GLYPH_GRID_EN
  assign grid = x_pos[GRID_LOG2-1:0] == '0 || vcount[GRID_LOG2-1:0] == '0;
  pipe_delay #(.W(24), .D(2)) u_grid_pal (.clk, .reset, .d(grid_color), .q(grid_c));
`else
  logic unused_grid;
  assign unused_grid = ^{grid_color, 32'(GRID_LOG2)};
  assign grid = 1'b0;
  assign grid_c = '0;
`endif
  assign s0 = '{bright: bright, hsync: hsync, vsync: vsync, pix_en: pix_en,
                bound: bound, grid: grid, track: track};
  pipe_delay #(.W($bits(flags_t)), .D(1), .RST(FLAGS_RST)) u_stage1 (.clk, .reset, .d(s0), .q(s1));
  pipe_delay #(.W($bits(flags_t)), .D(1), .RST(FLAGS_RST)) u_stage2 (.clk, .reset, .d(s1), .q(s2));
  pipe_delay #(.W(3), .D(1), .RST(3'b011)) u_stage3 (
    .clk, .reset, .d({s2.bright, s2.hsync, s2.vsync}), .q({bright_out, hsync_out, vsync_out}));
  pipe_delay #(.W(72), .D(2)) u_pal (
    .clk, .reset, .d({bound_color, track_color, bg_color}), .q(pal));
  always_comb
    next_rgb = !s2.bright ? '0 :
               (s2.pix_en && rom_data != TRANSPARENT) ? rom_data :
               s2.bound ? pal[71:48] :
               s2.grid ? grid_c :
               s2.track ? pal[47:24] : pal[23:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      rgb <= '0;
    end else begin
      rom_addr <= pix_en ? glyph_addr : '0;
      rgb <= next_rgb;
    end
  end
  // An edge counts only once both compared vsync samples were taken after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      live <= '0;
      frame_count <= '0;
    end else begin
      live <= {live[0], 1'b1};
      if (live[1] && s2.vsync && !s1.vsync) frame_count <= frame_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_glyph_pixel_mux.sv
// tb_glyph_pixel_mux: directed and randomized checks of glyph_pixel_mux against a spec-level model.
module tb_glyph_pixel_mux;
  logic clk = 0, reset = 1, bright = 0, hsync = 1, vsync = 1, pix_en = 0;
  logic [9:0] hcount = 0, vcount = 0;
  logic [15:0] glyph_addr = 0, rom_addr;
  logic [23:0] bg_color = 24'h98FB98, grid_color = 24'h228B22;
  logic [23:0] track_color = 24'h808069, bound_color = 24'hFFFFFF;
  logic [23:0] rom_data = 0, rgb;
  logic hsync_out, vsync_out, bright_out;
  logic [7:0] frame_count;
  int checks = 0, failures = 0;

  typedef struct {
    logic b, hs, vs, pe;
    logic [15:0] a;
    logic [9:0] hc, vc;
    logic [23:0] bg, gr, tr, bd;
  } px_t;

  glyph_pixel_mux dut (
    .clk(clk), .reset(reset), .bright(bright), .hsync(hsync), .vsync(vsync),
    .hcount(hcount), .vcount(vcount), .glyph_addr(glyph_addr), .pix_en(pix_en),
    .bg_color(bg_color), .grid_color(grid_color), .track_color(track_color),
    .bound_color(bound_color), .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .bright_out(bright_out),
    .frame_count(frame_count));

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_fn(input logic [15:0] a);
    if (a == 16'h0010) return 24'h123456;
    if (a == 16'h0020 || a[2:0] == 3'b111) return 24'hFF00FF;
    return {a[7:0], a[15:8] ^ 8'hA5, a[7:0] ^ 8'h3C};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  function automatic px_t mk(input int x, input int y, input logic b, input logic pe, input logic [15:0] a);
    px_t p;
    p.b = b; p.hs = 1; p.vs = 1; p.pe = pe; p.a = a;
    p.hc = 10'((x + 158) % 1024); p.vc = 10'(y);
    p.bg = 24'h98FB98; p.gr = 24'h228B22; p.tr = 24'h808069; p.bd = 24'hFFFFFF;
    return p;
  endfunction

  function automatic logic [23:0] exp_rgb(input px_t p);
    int x, y;
    logic [23:0] g;
    x = (int'(p.hc) + 1024 - 158) % 1024;
    y = int'(p.vc);
    g = rom_fn(p.a);
    if (!p.b) return 24'h0;
    if (p.pe && g != 24'hFF00FF) return g;
    if (x < 4 || x >= 636 || y < 4 || y >= 476) return p.bd;
`ifdef GLYPH_GRID_EN
    if (x % 32 == 0 || y % 32 == 0) return p.gr;
`endif
    if (y >= 400 && y < 448) return p.tr;
    return p.bg;
  endfunction

  task automatic drive(input px_t p);
    bright = p.b; hsync = p.hs; vsync = p.vs; pix_en = p.pe; glyph_addr = p.a;
    hcount = p.hc; vcount = p.vc;
    bg_color = p.bg; grid_color = p.gr; track_color = p.tr; bound_color = p.bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    px_t p;
    reset = 1;
    drive(mk(0, 0, 0, 0, 0));
    repeat (2) step();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      p = mk(100 + i, 100, 1, 1, 16'h0010);
      p.hs = 0;
      drive(p);
      step();
    end
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (rgb !== 0 || hsync_out !== 1 || vsync_out !== 1 || frame_count !== 0 ||
          bright_out !== 0 || rom_addr !== 0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got rgb=%h hs=%b vs=%b fc=%0d br=%b ra=%h exp rgb=0 hs=1 vs=1 fc=0 br=0 ra=0",
                 i, rgb, hsync_out, vsync_out, frame_count, bright_out, rom_addr);
      end
    end
    reset = 0;
    drive(mk(100, 100, 1, 1, 16'h0010));
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (rgb !== (k == 3 ? 24'h123456 : 24'h0)) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", k, rgb, k == 3 ? 24'h123456 : 24'h0);
      end
    end
  endtask

  task automatic test_glyph();
    drive(mk(100, 100, 1, 1, 16'h0010));
    step();
    checks++;
    if (rom_addr !== 16'h0010) begin
      failures++;
      $display("FAIL glyph_rom_addr got=%h exp=0010", rom_addr);
    end
    drive(mk(0, 0, 0, 0, 0));
    repeat (2) step();
    checks++;
    if (rgb !== 24'h123456 || bright_out !== 1) begin
      failures++;
      $display("FAIL glyph_rgb got=%h/%b exp=123456/1", rgb, bright_out);
    end
  endtask

  task automatic test_transparent();
    drive(mk(100, 410, 1, 1, 16'h0020));
    step();
    drive(mk(0, 0, 0, 0, 0));
    repeat (2) step();
    checks++;
    if (rgb !== 24'h808069) begin
      failures++;
      $display("FAIL transparent_track got=%h exp=808069", rgb);
    end
  endtask

  task automatic test_grid();
    logic [23:0] e;
`ifdef GLYPH_GRID_EN
    e = 24'h228B22;
`else
    e = 24'h98FB98;
`endif
    drive(mk(64, 100, 1, 0, 0));
    step();
    drive(mk(2, 100, 1, 0, 0));
    step();
    drive(mk(0, 0, 0, 0, 0));
    step();
    checks++;
    if (rgb !== e) begin
      failures++;
      $display("FAIL grid_x64 got=%h exp=%h", rgb, e);
    end
    step();
    checks++;
    if (rgb !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL bound_x2 got=%h exp=ffffff", rgb);
    end
  endtask

  task automatic test_blank();
    drive(mk(100, 100, 0, 1, 16'h0010));
    step();
    checks++;
    if (rom_addr !== 16'h0010) begin
      failures++;
      $display("FAIL blank_rom_addr got=%h exp=0010", rom_addr);
    end
    drive(mk(0, 0, 0, 0, 0));
    repeat (2) step();
    checks++;
    if (rgb !== 0 || bright_out !== 0) begin
      failures++;
      $display("FAIL blank_rgb got=%h/%b exp=0/0", rgb, bright_out);
    end
  endtask

  task automatic test_random();
    px_t q[$];
    px_t p, e;
    for (int i = 0; i < 400; i++) begin
      p.b = $urandom_range(0, 3) != 0;
      p.hs = 1'($urandom);
      p.vs = 1'($urandom);
      p.pe = 1'($urandom);
      p.a = ($urandom_range(0, 7) == 0) ? 16'h0020 : 16'($urandom);
      p.hc = 10'($urandom);
      p.vc = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(396, 452)) : 10'($urandom);
      p.bg = 24'($urandom); p.gr = 24'($urandom); p.tr = 24'($urandom); p.bd = 24'($urandom);
      drive(p);
      q.push_back(p);
      step();
      checks++;
      if (rom_addr !== (p.pe ? p.a : 16'h0)) begin
        failures++;
        $display("FAIL rand_rom_addr i=%0d got=%h exp=%h", i, rom_addr, p.pe ? p.a : 16'h0);
      end
      if (q.size() == 3) begin
        e = q.pop_front();
        checks++;
        if (rgb !== exp_rgb(e) || bright_out !== e.b || hsync_out !== e.hs || vsync_out !== e.vs) begin
          failures++;
          $display("FAIL rand_pixel i=%0d got rgb=%h br=%b hs=%b vs=%b exp rgb=%h br=%b hs=%b vs=%b",
                   i, rgb, bright_out, hsync_out, vsync_out, exp_rgb(e), e.b, e.hs, e.vs);
        end
      end
    end
  endtask

  task automatic test_frames();
    logic [7:0] e;
    reset = 1;
    drive(mk(0, 0, 0, 0, 0));
    repeat (2) step();
    reset = 0;
    repeat (4) step();
    checks++;
    if (frame_count !== 0) begin
      failures++;
      $display("FAIL frame_start got=%0d exp=0", frame_count);
    end
    for (int k = 0; k < 256; k++) begin
      vsync = 0;
      step();
      e = 8'(k);
      checks++;
      if (frame_count !== e) begin
        failures++;
        $display("FAIL frame_early k=%0d got=%0d exp=%0d", k, frame_count, e);
      end
      step();
      e = 8'((k + 1) % 256);
      checks++;
      if (frame_count !== e) begin
        failures++;
        $display("FAIL frame_inc k=%0d got=%0d exp=%0d", k, frame_count, e);
      end
      step();
      vsync = 1;
      repeat (2) step();
    end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_transparent();
    test_grid();
    test_blank();
    test_random();
    test_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/glyph_pixel_mux.md
# glyph_pixel_mux

Downstream stage of the glyph address generator in the VGA path. Takes the per-pixel glyph address, pixel-enable and palette colors, reads the glyph ROM, and applies glyph transparency. It then picks the final 24-bit RGB by fixed priority: glyph, boundary, grid, track, background. Sync and blanking are delayed to match the pipeline, and the block counts frames for sprite animation.

## Interface
Parameters:
- H_START, 158, hcount value of first visible column (x_pos = hcount - H_START)
- DISPLAY_W, 640, visible width in pixels
- DISPLAY_H, 480, visible height in lines
- BORDER, 4, boundary band thickness in pixels
- TRACK_Y0, 400, first track line (inclusive)
- TRACK_Y1, 448, last track line (exclusive)
- GRID_LOG2, 5, grid pitch = 2^GRID_LOG2 pixels
- TRANSPARENT, 24'hFF00FF, glyph color treated as see-through

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- bright  in  1  visible-region flag from timing generator
- hsync, vsync  in  1  active-low syncs from timing generator
- hcount, vcount  in  10  raster counters
- glyph_addr  in  16  glyph ROM address from address generator
- pix_en  in  1  glyph_addr valid for this pixel
- bg_color, grid_color, track_color, bound_color  in  24  palette
- rom_addr  out  16  registered glyph ROM address
- rom_data  in  24  glyph ROM data, exactly 1 cycle after rom_addr
- rgb  out  24  final pixel color {R,G,B}
- hsync_out, vsync_out  out  1  syncs delayed to match rgb
- bright_out  out  1  bright delayed to match rgb
- frame_count  out  8  completed-frame counter

## Operation
- Stage 1, cycle N+1: register rom_addr <= pix_en ? glyph_addr : 0. Register pix_en, bright, syncs, the palette, and the region flags computed from hcount/vcount at N.
- Region flags use x_pos = hcount - H_START, 10-bit unsigned with wrap, and y_pos = vcount.
  - bound: x_pos < BORDER, x_pos >= DISPLAY_W-BORDER, y_pos < BORDER, or y_pos >= DISPLAY_H-BORDER.
  - grid: x_pos[GRID_LOG2-1:0]==0 or y_pos[GRID_LOG2-1:0]==0.
  - track: TRACK_Y0 <= y_pos < TRACK_Y1.
- Stage 2, cycle N+2: rom_data valid; carry all stage-1 flags forward.
- Stage 3, cycle N+3: register rgb using the first matching rule:
  - bright=0: 0
  - pix_en=1 and rom_data != TRANSPARENT: rom_data
  - bound: bound_color
  - grid (if enabled): grid_color
  - track: track_color
  - otherwise: bg_color
- Palette values are sampled at stage 1 with their pixel, so a mid-line palette change affects only later pixels.
- frame_count increments by 1 on each vsync falling edge, seen as registered vsync 1 -> 0. It wraps 255 -> 0.
- pix_en=1 on a non-visible pixel: the ROM is still read, but rgb=0.

## Timing
- Latency is exactly 3 cycles from hcount/vcount/glyph_addr/pix_en/bright/sync to rgb/hsync_out/vsync_out/bright_out.
- rom_addr changes 1 cycle after its input. ROM read latency is fixed at 1 cycle; there is no handshake.
- Reset values: rom_addr=0, rgb=0, bright_out=0, hsync_out=1, vsync_out=1, frame_count=0. All pipeline flags clear.
- Reset mid-frame: outputs hold their reset values while reset=1. The first valid pixel appears 3 cycles after reset deasserts. No frame_count edge is detected on the reset-release cycle.
- A vsync edge coinciding with reset is ignored.

## Configuration
- GLYPH_GRID_EN:
  - Defined: the grid rule is active between bound and track.
  - Undefined: grid logic is not compiled, grid_color is ignored, and grid pixels show track or bg.
  - Latency is unchanged either way.

## Structure
- Shared package vga_pkg: the H_START/DISPLAY_W/DISPLAY_H constants, the 24-bit color typedef, TRANSPARENT, and default palette constants (BG 98FB98, GRID 228B22, TRACK 808069, BOUND FFFFFF).
- One sub-module: pipe_delay (parameterised width and depth, reset value per instance). It delays bright/hsync/vsync and the region flags.

## Test plan
- Reset held 5 cycles mid-line: rgb=0, hsync_out=vsync_out=1, frame_count=0. First non-zero rgb appears exactly 3 cycles after release.
- bright=1, pix_en=1, glyph_addr=0x0010, ROM returns 0x123456: rom_addr=0x0010 at N+1, rgb=0x123456 at N+3.
- Same pixel with ROM returning 0xFF00FF at x_pos=100, y_pos=410: rgb=track_color 0x808069.
- pix_en=0 at x_pos=64, y_pos=100: GLYPH_GRID_EN defined gives rgb=0x228B22; undefined gives 0x98FB98. At x_pos=2 both give bound 0xFFFFFF.
- bright=0 with pix_en=1 and opaque ROM data: rgb=0, bright_out=0 at N+3.
- 256 vsync falling edges: frame_count reaches 255, then wraps to 0. Each increment is 1 cycle after the edge enters stage 1.
